// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: opcodes, FSM states and divider counter sizing for ex_muldiv
package ex_muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_MADD  = 3'd2,
      MD_MADDU = 3'd3,
      MD_MSUB  = 3'd4,
      MD_MSUBU = 3'd5,
      MD_DIV   = 3'd6,
      MD_DIVU  = 3'd7
   } md_op_e;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MUL      = 3'd1,
      S_DIV_ZERO = 3'd2,
      S_DIV_RUN  = 3'd3,
      S_DONE     = 3'd4
   } md_state_e;

   // Width of the divider step counter: it must hold 0..WIDTH/DIV_STEP.
   function automatic int div_step_bus_w(input int width, input int step);
      return $clog2(width / step + 1);
   endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// ex_muldiv_div_core: restoring unsigned divider, S quotient bits per step
module ex_muldiv_div_core
   import ex_muldiv_pkg::*;
#(
   parameter int W = 32,
   parameter int S = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] quot_o,
   output logic [W-1:0] rem_o,
   output logic         done_o
);

   localparam int N  = W / S;
   localparam int CW = div_step_bus_w(W, S);

   logic [W-1:0]  rem_q, rem_d, quot_q, quot_d, div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    r;
   logic [W-1:0]  q;

   assign done_o = cnt_q == CW'(N);
   assign quot_o = quot_q;
   assign rem_o  = rem_q;

   // The quotient register doubles as the dividend shifter: dividend bits leave at the top
   // while quotient bits enter at the bottom.
   always_comb begin
      rem_d  = rem_q;
      quot_d = quot_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      r      = '0;
      q      = '0;
      if (load_i) begin
         rem_d  = '0;
         quot_d = dividend_i;
         div_d  = divisor_i;
         cnt_d  = '0;
      end else if (step_i && !done_o) begin
         r = {1'b0, rem_q};
         q = quot_q;
         for (int i = 0; i < S; i++) begin
            r = {r[W-1:0], q[W-1]};
            q = {q[W-2:0], 1'b0};
            if (r >= {1'b0, div_q}) begin
               r    = r - {1'b0, div_q};
               q[0] = 1'b1;
            end
         end
         rem_d  = r[W-1:0];
         quot_d = q;
         cnt_d  = cnt_q + CW'(1);
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q  <= '0;
         quot_q <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
      end else begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative EX-stage multiply/accumulate/divide unit writing HI/LO
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DIV_STEP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             annul_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   output logic             stall_req_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             whilo_o
);

   md_state_e          state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hacc_q, hacc_d, lacc_q, lacc_d, hi_q, hi_d, lo_q, lo_d;
   logic               accept, is_div_in, sg_in, sg, div_load, div_step, div_done;
   logic [WIDTH-1:0]   dvd_mag, dvs_mag, quot, rem, q_fix, r_fix;
   logic [2*WIDTH-1:0] ax, bx, prod, acc, mul_res;

   assign accept      = (state_q == S_IDLE) & start_i & ~annul_i;
   assign is_div_in   = op_i[2] & op_i[1];
   assign sg_in       = ~op_i[0];
   assign dvd_mag     = (sg_in & opa_i[WIDTH-1]) ? -opa_i : opa_i;
   assign dvs_mag     = (sg_in & opb_i[WIDTH-1]) ? -opb_i : opb_i;
   assign div_load    = accept & is_div_in & (opb_i != '0);
   assign div_step    = (state_q == S_DIV_RUN) & ~annul_i;
   assign stall_req_o = (accept & rst) | (state_q inside {S_MUL, S_DIV_ZERO, S_DIV_RUN});
   assign ready_o     = (state_q == S_DONE) & ~annul_i;
   assign whilo_o     = ready_o;
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;

   ex_muldiv_div_core #(.W(WIDTH), .S(DIV_STEP)) u_div (
      .clk        (clk),
      .rst        (rst),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i (dvd_mag),
      .divisor_i  (dvs_mag),
      .quot_o     (quot),
      .rem_o      (rem),
      .done_o     (div_done)
   );

   // Full-width product (sign- or zero-extended operands, so one multiplier serves both),
   // accumulate against forwarded HI/LO, and signed division fix-up.
   always_comb begin
      sg      = ~op_q[0];
      ax      = {{WIDTH{sg & a_q[WIDTH-1]}}, a_q};
      bx      = {{WIDTH{sg & b_q[WIDTH-1]}}, b_q};
      prod    = ax * bx;
      acc     = {hacc_q, lacc_q};
      mul_res = (op_q[2:1] == 2'b01) ? acc + prod : (op_q[2:1] == 2'b10) ? acc - prod : prod;
      q_fix   = (sg & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quot : quot;
      r_fix   = (sg & a_q[WIDTH-1]) ? -rem : rem;
   end

   // Next state and result capture; annul overrides everything and leaves HI/LO untouched.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_d    = accept ? op_i : op_q;
      a_d     = accept ? opa_i : a_q;
      b_d     = accept ? opb_i : b_q;
      hacc_d  = accept ? hi_i : hacc_q;
      lacc_d  = accept ? lo_i : lacc_q;
      case (state_q)
         S_IDLE:     if (accept) state_d = !is_div_in ? S_MUL : (opb_i == '0) ? S_DIV_ZERO : S_DIV_RUN;
         S_MUL: begin
            state_d      = S_DONE;
            {hi_d, lo_d} = mul_res;
         end
         S_DIV_ZERO: begin
            state_d = S_DONE;
            hi_d    = '0;
            lo_d    = '0;
         end
         S_DIV_RUN: if (div_done) begin
            state_d = S_DONE;
            hi_d    = r_fix;
            lo_d    = q_fix;
         end
         default:    state_d = S_IDLE;
      endcase
      if (annul_i) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State, latched operands and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hacc_q  <= '0;
         lacc_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hacc_q  <= hacc_d;
         lacc_q  <= lacc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule
